// File: rtl/register_file_n.sv
// Parameterised multi-ported register file with a per-register pending
// scoreboard, optional hardwired zero register and write-to-read forwarding.
module register_file_n #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned AW       = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             regwr,
    input  logic [AW-1:0]    rd,
    input  logic [WIDTH-1:0] data,
    input  logic             mark,
    input  logic [AW-1:0]    mrd,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    rb,
    output logic [WIDTH-1:0] outa,
    output logic [WIDTH-1:0] outb,
    output logic             busya,
    output logic             busyb
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_next;

    logic             wr_eff;
    logic             mark_eff;
    logic             fwd_a;
    logic             fwd_b;
    logic [WIDTH-1:0] stored_a;
    logic [WIDTH-1:0] stored_b;

    always_comb begin
        wr_eff   = regwr && !rst && !(ZERO_REG && (rd == '0));
        mark_eff = mark && !rst && !(ZERO_REG && (mrd == '0));
    end

    // Clear for the completing write first, then set for the new issue, so
    // a mark to the same register in the same cycle keeps it pending.
    always_comb begin
        pending_next = pending;
        if (wr_eff) begin
            pending_next[rd] = 1'b0;
        end
        if (mark_eff) begin
            pending_next[mrd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs    <= '{default: '0};
            pending <= '0;
        end else begin
            if (wr_eff) begin
                regs[rd] <= data;
            end
            pending <= pending_next;
        end
    end

    // Register 0 is masked on read so it is zero even before the first reset.
    always_comb begin
        stored_a = (ZERO_REG && (ra == '0)) ? '0 : regs[ra];
        stored_b = (ZERO_REG && (rb == '0)) ? '0 : regs[rb];
        fwd_a    = BYPASS && wr_eff && (ra == rd);
        fwd_b    = BYPASS && wr_eff && (rb == rd);
    end

    always_comb begin
        outa  = fwd_a ? data : stored_a;
        outb  = fwd_b ? data : stored_b;
        busya = pending[ra] && !fwd_a;
        busyb = pending[rb] && !fwd_b;
    end

endmodule

// File: tb/tb_register_file_n.sv
// Directed self-checking bench: default, no-bypass and narrow/no-zero-reg
// configurations of register_file_n driven with hand-computed vectors.
module tb_register_file_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // default (A) and BYPASS=0 (C) instances share stimulus
    logic        rst, regwr, mark;
    logic [4:0]  rd, mrd, ra, rb;
    logic [31:0] data;
    logic [31:0] a_outa, a_outb, c_outa, c_outb;
    logic        a_busya, a_busyb, c_busya, c_busyb;

    // narrow instance (B)
    logic        b_rst, b_regwr, b_mark;
    logic [2:0]  b_rd, b_mrd, b_ra, b_rb;
    logic [15:0] b_data, b_outa, b_outb;
    logic        b_busya, b_busyb;

    register_file_n #(.WIDTH(32), .AW(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_a (
        .clk(clk), .rst(rst), .regwr(regwr), .rd(rd), .data(data),
        .mark(mark), .mrd(mrd), .ra(ra), .rb(rb),
        .outa(a_outa), .outb(a_outb), .busya(a_busya), .busyb(a_busyb)
    );

    register_file_n #(.WIDTH(32), .AW(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_c (
        .clk(clk), .rst(rst), .regwr(regwr), .rd(rd), .data(data),
        .mark(mark), .mrd(mrd), .ra(ra), .rb(rb),
        .outa(c_outa), .outb(c_outb), .busya(c_busya), .busyb(c_busyb)
    );

    register_file_n #(.WIDTH(16), .AW(3), .ZERO_REG(1'b0), .BYPASS(1'b1)) u_b (
        .clk(clk), .rst(b_rst), .regwr(b_regwr), .rd(b_rd), .data(b_data),
        .mark(b_mark), .mrd(b_mrd), .ra(b_ra), .rb(b_rb),
        .outa(b_outa), .outb(b_outb), .busya(b_busya), .busyb(b_busyb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one edge, then let outputs settle off the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        regwr = 1'b0; mark = 1'b0; rst = 1'b0;
        b_regwr = 1'b0; b_mark = 1'b0; b_rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; regwr = 1'b0; mark = 1'b0;
        rd = '0; mrd = '0; ra = '0; rb = '0; data = '0;
        b_rst = 1'b1; b_regwr = 1'b0; b_mark = 1'b0;
        b_rd = '0; b_mrd = '0; b_ra = '0; b_rb = '0; b_data = '0;
        tick();
        tick();
        idle();

        // reset state
        ra = 5'd5; rb = 5'd31; #1;
        check("rst_outa", a_outa, 32'h0);
        check("rst_outb", a_outb, 32'h0);
        check("rst_busya", {31'b0, a_busya}, 32'h0);
        check("rst_busyb", {31'b0, a_busyb}, 32'h0);
        check("rst_c_outb", c_outb, 32'h0);

        // write with same-cycle read of the target
        regwr = 1'b1; rd = 5'd3; data = 32'hDEADBEEF; ra = 5'd3; #1;
        check("byp_outa", a_outa, 32'hDEADBEEF);
        check("nobyp_old", c_outa, 32'h0);
        tick();
        idle(); #1;
        check("wr3_outa", a_outa, 32'hDEADBEEF);
        check("nobyp_new", c_outa, 32'hDEADBEEF);

        // register 0 stays zero and never goes pending
        regwr = 1'b1; rd = 5'd0; data = 32'hFFFFFFFF; mark = 1'b1; mrd = 5'd0; ra = 5'd0; #1;
        check("r0_byp", a_outa, 32'h0);
        check("r0_busy_now", {31'b0, a_busya}, 32'h0);
        tick();
        idle(); #1;
        check("r0_outa", a_outa, 32'h0);
        check("r0_busya", {31'b0, a_busya}, 32'h0);
        check("r0_c_outa", c_outa, 32'h0);

        // scoreboard set / set-wins / clear
        mark = 1'b1; mrd = 5'd7; ra = 5'd7; #1;
        check("mk7_pre", {31'b0, a_busya}, 32'h0);
        tick();
        idle(); #1;
        check("mk7_busy", {31'b0, a_busya}, 32'h1);
        regwr = 1'b1; rd = 5'd7; data = 32'h77; mark = 1'b1; mrd = 5'd7; #1;
        check("mkwr7_byp_busy", {31'b0, a_busya}, 32'h0);
        check("mkwr7_nobyp_busy", {31'b0, c_busya}, 32'h1);
        tick();
        idle(); #1;
        check("setwins_busy", {31'b0, a_busya}, 32'h1);
        check("setwins_data", a_outa, 32'h77);
        regwr = 1'b1; rd = 5'd7; data = 32'h88; #1;
        check("clr7_c_busy_now", {31'b0, c_busya}, 32'h1);
        tick();
        idle(); #1;
        check("clr7_busy", {31'b0, a_busya}, 32'h0);
        check("clr7_c_busy", {31'b0, c_busya}, 32'h0);
        check("clr7_data", a_outa, 32'h88);

        // independent mark and write on different registers
        mark = 1'b1; mrd = 5'd10; regwr = 1'b1; rd = 5'd11; data = 32'h1111;
        tick();
        idle(); ra = 5'd10; rb = 5'd11; #1;
        check("ind_busya", {31'b0, a_busya}, 32'h1);
        check("ind_busyb", {31'b0, a_busyb}, 32'h0);
        check("ind_outb", a_outb, 32'h1111);

        // bypass on both ports at once
        regwr = 1'b1; rd = 5'd20; data = 32'hCAFE; ra = 5'd20; rb = 5'd20; #1;
        check("dual_byp_a", a_outa, 32'hCAFE);
        check("dual_byp_b", a_outb, 32'hCAFE);
        check("dual_nobyp_b", c_outb, 32'h0);
        tick();
        idle();

        // reset drops a same-cycle write and disables bypass
        rst = 1'b1; regwr = 1'b1; rd = 5'd9; data = 32'h12345678; ra = 5'd9; rb = 5'd3; #1;
        check("rstwr_byp", a_outa, 32'h0);
        tick();
        idle(); #1;
        check("rstwr_r9", a_outa, 32'h0);
        check("rst_clr_r3", a_outb, 32'h0);

        // pending bits cleared by mid-operation reset
        mark = 1'b1; mrd = 5'd4; tick();
        mrd = 5'd12; tick();
        idle(); ra = 5'd4; rb = 5'd12; #1;
        check("pend4", {31'b0, a_busya}, 32'h1);
        check("pend12", {31'b0, a_busyb}, 32'h1);
        rst = 1'b1; mark = 1'b1; mrd = 5'd4; tick();
        idle(); #1;
        check("pend4_rst", {31'b0, a_busya}, 32'h0);
        check("pend12_rst", {31'b0, a_busyb}, 32'h0);

        // narrow configuration, register 0 ordinary
        b_regwr = 1'b1; b_rd = 3'd0; b_data = 16'hA5A5; b_ra = 3'd0; #1;
        check("b_r0_byp", {16'b0, b_outa}, 32'hA5A5);
        tick();
        b_regwr = 1'b0; #1;
        check("b_r0_outa", {16'b0, b_outa}, 32'hA5A5);
        b_regwr = 1'b1; b_rd = 3'd7; b_data = 16'h5A5A;
        tick();
        b_regwr = 1'b0; b_ra = 3'd7; b_rb = 3'd7; #1;
        check("b_r7_a", {16'b0, b_outa}, 32'h5A5A);
        check("b_r7_b", {16'b0, b_outb}, 32'h5A5A);
        b_mark = 1'b1; b_mrd = 3'd0;
        tick();
        b_mark = 1'b0; b_ra = 3'd0; #1;
        check("b_r0_pend", {31'b0, b_busya}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
